// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the multi-cycle core's load/store path. One word request
// is accepted at a time over a valid/ready handshake, held for WAIT_CYCLES
// wait states, and then performed once as a byte-enabled store or a word
// load. The result goes back over a second valid/ready handshake.
//
// Parameters
//   ADDR_W       word-address width; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between accept and access (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req_valid    request present
//   req_ready    responder idle and able to accept a request
//   req_write    1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    store data
//   req_be       store byte enables; bit i selects wdata[8i+7:8i]
//   resp_valid   response present
//   resp_ready   core takes the response
//   resp_rdata   load data; 0 for stores and errors
//   resp_err     request was misaligned or outside the array
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    // First byte-address bit that lies above the word array.
    localparam int         HI_LSB   = ADDR_W + 2;
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]  cnt;

    // Request captured on the accept edge; later input changes are ignored.
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              access;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_addr;
    logic [31:0]       addr_hi;
    logic [ADDR_W-1:0] word_idx;

    // -------------------------------------------------------------------------
    // Decode of the latched request
    // -------------------------------------------------------------------------
    assign accept       = (state == IDLE) && req_valid;
    // The single memory access happens on the WAIT-to-RESP edge.
    assign access       = (state == WAIT) && (cnt == 4'd0);

    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign addr_hi      = addr_q >> HI_LSB;
    assign out_of_range = (addr_hi != 32'd0);
    assign bad_addr     = misaligned || out_of_range;
    assign word_idx     = addr_q[ADDR_W+1:2];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                // req_ready stays low here, so no request can be taken on
                // the same edge the response completes.
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded purely from state; never both high.
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Wait-state counter: loaded on accept, counts down to zero in WAIT.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; contents are undefined after power-up.
    // A reset during WAIT forces the FSM to IDLE, so access is low and the
    // pending store never reaches the array.
    always_ff @(posedge clk) begin
        if (access && write_q && !bad_addr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response registers: loaded once at the access edge and held through
    // RESP until the handshake, however long the core back-pressures.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (access) begin
            if (bad_addr) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end else if (write_q) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end else begin
                rdata_q <= mem[word_idx];
                err_q   <= 1'b0;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Instance "a" uses WAIT_CYCLES=2 and
// covers reset, word/byte stores, loads, error responses and back-pressure.
// Instance "z" uses WAIT_CYCLES=0 and covers back-to-back load throughput.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_resp_valid, a_resp_ready;
    logic [31:0] a_resp_rdata;
    logic        a_resp_err;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_valid, z_resp_ready;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .req_be     (a_req_be),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_z (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_be     (z_req_be),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        if (sel) begin
            z_req_valid = v; z_req_write = wr; z_req_addr = addr;
            z_req_wdata = wdata; z_req_be = be;
        end else begin
            a_req_valid = v; a_req_write = wr; a_req_addr = addr;
            a_req_wdata = wdata; a_req_be = be;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? z_req_ready : a_req_ready;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? z_resp_valid : a_resp_valid;
    endfunction

    // One full transaction with resp_ready held high. Starts and ends at
    // 1 time unit after a rising edge with the responder idle. lat counts the
    // edges after the accept edge until resp_valid is seen.
    task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        drive(sel, 1'b1, wr, addr, wdata, be);
        guard = 0;
        while (!get_ready(sel) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        lat = 0;
        while (!get_valid(sel) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("resp_seen", 32'(get_valid(sel)), 32'd1);
        rd = sel ? z_resp_rdata : a_resp_rdata;
        er = sel ? z_resp_err : a_resp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] z_exp [3];
    int          acc_cyc [4];
    int          n_acc, n_resp, cyc, last_resp, guard;
    logic        pr;

    initial begin
        rst = 1'b0;
        a_resp_ready = 1'b1;
        z_resp_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2;
        check("rst_req_ready",  32'(a_req_ready),  32'd1);
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_resp_rdata", a_resp_rdata,      32'd0);
        check("rst_resp_err",   32'(a_resp_err),   32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store then load, with the load latency measured.
        do_req(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
        check("st20_rdata", rd, 32'd0);
        check("st20_err",   32'(er), 32'd0);
        do_req(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat);
        check("ld20_rdata", rd, 32'h12345678);
        check("ld20_err",   32'(er), 32'd0);
        check("ld20_lat",   32'(lat), 32'd3);

        // Byte enables, including an all-zero enable that must leave memory alone.
        do_req(1'b0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h24, 32'h000000AA, 4'h1, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h24, 32'h00BB0000, 4'h4, rd, er, lat);
        do_req(1'b0, 1'b0, 32'h24, 32'd0, 4'h0, rd, er, lat);
        check("ld24_bytes", rd, 32'hFFBBFFAA);
        do_req(1'b0, 1'b1, 32'h24, 32'h11223344, 4'h0, rd, er, lat);
        check("st24_be0_err", 32'(er), 32'd0);
        do_req(1'b0, 1'b0, 32'h24, 32'd0, 4'h0, rd, er, lat);
        check("ld24_after_be0", rd, 32'hFFBBFFAA);

        // Errors: misaligned load, out-of-range store, aliased word untouched.
        do_req(1'b0, 1'b0, 32'h22, 32'd0, 4'h0, rd, er, lat);
        check("ld22_err",   32'(er), 32'd1);
        check("ld22_rdata", rd, 32'd0);
        do_req(1'b0, 1'b1, 32'h000, 32'hCAFEF00D, 4'hF, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h400, 32'h55555555, 4'hF, rd, er, lat);
        check("st400_err",   32'(er), 32'd1);
        check("st400_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h000, 32'd0, 4'h0, rd, er, lat);
        check("ld000_alias", rd, 32'hCAFEF00D);
        check("ld000_err",   32'(er), 32'd0);

        // Reset in the middle of a store's wait states.
        do_req(1'b0, 1'b1, 32'h10, 32'h11111111, 4'hF, rd, er, lat);
        do_req(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
        check("ld10_before", rd, 32'h11111111);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("midwait_ready", 32'(a_req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_req_ready",  32'(a_req_ready),  32'd1);
        check("arst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("arst_resp_rdata", a_resp_rdata,      32'd0);
        check("arst_resp_err",   32'(a_resp_err),   32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(a_resp_valid), 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
        check("ld10_after_rst", rd, 32'h11111111);

        // Back-pressure with a second request already waiting.
        a_resp_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h24, 32'd0, 4'h0);
        guard = 0;
        while (!a_resp_valid && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(a_resp_valid), 32'd1);
            check("bp_rdata", a_resp_rdata, 32'h12345678);
            check("bp_ready", 32'(a_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 32'(a_req_ready),  32'd1);
        check("bp_idle_valid", 32'(a_resp_valid), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("bp_second_accepted", 32'(a_req_ready), 32'd0);
        lat = 0;
        while (!a_resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("bp_second_lat",   32'(lat), 32'd3);
        check("bp_second_rdata", a_resp_rdata, 32'hFFBBFFAA);
        @(posedge clk); #1;

        // Zero-wait instance: preload three words, then stream loads.
        z_exp[0] = 32'hA0A0A0A0;
        z_exp[1] = 32'h0B0B0B0B;
        z_exp[2] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 1'b1, 32'(4 * i), z_exp[i], 4'hF, rd, er, lat);
        end
        do_req(1'b1, 1'b0, 32'h4, 32'd0, 4'h0, rd, er, lat);
        check("z_lat", 32'(lat), 32'd1);

        n_acc = 0; n_resp = 0; cyc = 0; last_resp = 0;
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
        for (int k = 0; k < 30 && n_resp < 3; k++) begin
            pr = z_req_ready && z_req_valid;
            @(posedge clk); #1;
            cyc++;
            if (pr && n_acc < 4) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                drive(1'b1, 1'b1, 1'b0, 32'(4 * n_acc), 32'd0, 4'h0);
            end
            if (z_resp_valid) begin
                check("z_b2b_rdata", z_resp_rdata, z_exp[n_resp]);
                check("z_b2b_lat", 32'(cyc - acc_cyc[n_resp]), 32'd1);
                if (n_resp > 0) begin
                    check("z_b2b_spacing", 32'(cyc - last_resp), 32'd3);
                end
                last_resp = cyc;
                n_resp++;
                if (n_resp == 3) begin
                    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
                end
            end
        end
        check("z_b2b_count", 32'(n_resp), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (4) @(posedge clk);
        #1;
        check("z_final_idle", 32'(z_req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
